// File: rtl/rf_access_seq_pkg.sv
// Shared definitions for the register-file access sequencer: op codes, register
// indices, flag bit positions and the sequencer state encoding.
package rf_access_seq_pkg;

   localparam int unsigned RF_W  = 8;
   localparam int unsigned NREG  = 5;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned OP_W  = 2;

   localparam logic [OP_W-1:0] OP_NOP = 2'b00;
   localparam logic [OP_W-1:0] OP_LDI = 2'b01;
   localparam logic [OP_W-1:0] OP_RD  = 2'b10;
   localparam logic [OP_W-1:0] OP_MOV = 2'b11;

   localparam logic [IDX_W-1:0] REG_A = 3'd0;
   localparam logic [IDX_W-1:0] REG_B = 3'd1;
   localparam logic [IDX_W-1:0] REG_C = 3'd2;
   localparam logic [IDX_W-1:0] REG_D = 3'd3;
   localparam logic [IDX_W-1:0] REG_F = 3'd4;

   localparam int unsigned FLG_Z = 0;
   localparam int unsigned FLG_N = 1;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      FLAG,
      RESP
   } state_t;

endpackage

// File: rtl/rf_access_seq_sel_decode.sv
// Register index to one-hot select decoder with an out-of-range flag.
module rf_sel_decode
   import rf_access_seq_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [NREG-1:0]  sel,
   output logic             bad
);

   always_comb begin
      sel = '0;
      bad = (idx >= IDX_W'(NREG));
      for (int unsigned i = 0; i < NREG; i++) begin
         sel[i] = (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/rf_access_seq.sv
// Register-file access sequencer: turns LDI/RD/MOV requests into rf strobe cycles.
// Define RF_FLAG_UPDATE_EN to append an N/Z flag-register write after LDI/MOV to A..D.
module rf_access_seq
   import rf_access_seq_pkg::*;
#(
   parameter int unsigned W = RF_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OP_W-1:0]  req_op,
   input  logic [IDX_W-1:0] req_src,
   input  logic [IDX_W-1:0] req_dst,
   input  logic [W-1:0]     req_imm,
   output logic             rsp_valid,
   output logic [W-1:0]     rsp_data,
   output logic             rsp_err,
   output logic             rf_as,
   output logic             rf_bs,
   output logic             rf_cs,
   output logic             rf_ds,
   output logic             rf_fs,
   output logic             rf_re,
   output logic             rf_we,
   output logic [W-1:0]     rf_d,
   input  logic [W-1:0]     rf_p,
   input  logic [W-1:0]     rf_fo
);

   state_t          state;
   logic [NREG-1:0] src_sel;
   logic [NREG-1:0] dst_sel;
   logic [NREG-1:0] dst_sel_q;
   logic [NREG-1:0] sel;
   logic            src_bad;
   logic            dst_bad;
   logic            req_bad;
   logic            is_mov_q;
   logic            src_f_q;
   logic [W-1:0]    data_q;
   logic [W-1:0]    rd_val;
`ifdef RF_FLAG_UPDATE_EN
   logic            dst_f_q;
   logic [W-1:0]    flag_d;
`endif

   rf_sel_decode u_src_dec (
      .idx (req_src),
      .sel (src_sel),
      .bad (src_bad)
   );

   rf_sel_decode u_dst_dec (
      .idx (req_dst),
      .sel (dst_sel),
      .bad (dst_bad)
   );

   assign req_ready = (state == IDLE);
   assign rf_as     = sel[REG_A];
   assign rf_bs     = sel[REG_B];
   assign rf_cs     = sel[REG_C];
   assign rf_ds     = sel[REG_D];
   assign rf_fs     = sel[REG_F];

   // F is not on the shared p bus; its value comes from the dedicated fo port
   assign rd_val = src_f_q ? rf_fo : rf_p;

   // Only operands the op actually uses can make the request illegal
   always_comb begin
      req_bad = 1'b0;
      unique case (req_op)
         OP_LDI:  req_bad = dst_bad;
         OP_RD:   req_bad = src_bad;
         OP_MOV:  req_bad = src_bad || dst_bad;
         default: req_bad = 1'b0;
      endcase
   end

`ifdef RF_FLAG_UPDATE_EN
   always_comb begin
      flag_d        = '0;
      flag_d[FLG_N] = data_q[W-1];
      flag_d[FLG_Z] = (data_q == '0);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= '0;
         rf_re     <= 1'b0;
         rf_we     <= 1'b0;
         rf_d      <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         dst_sel_q <= '0;
         is_mov_q  <= 1'b0;
         src_f_q   <= 1'b0;
         data_q    <= '0;
`ifdef RF_FLAG_UPDATE_EN
         dst_f_q   <= 1'b0;
`endif
      end else begin
         sel       <= '0;
         rf_re     <= 1'b0;
         rf_we     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  dst_sel_q <= dst_sel;
                  is_mov_q  <= (req_op == OP_MOV);
                  src_f_q   <= (req_src == REG_F);
`ifdef RF_FLAG_UPDATE_EN
                  dst_f_q   <= (req_dst == REG_F);
`endif
                  if ((req_op == OP_NOP) || req_bad) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= req_bad;
                     rsp_data  <= '0;
                  end else if (req_op == OP_LDI) begin
                     state  <= WRITE;
                     sel    <= dst_sel;
                     rf_we  <= 1'b1;
                     rf_d   <= req_imm;
                     data_q <= req_imm;
                  end else begin
                     state <= READ;
                     sel   <= src_sel;
                     rf_re <= 1'b1;
                  end
               end
            end
            READ: begin
               data_q <= rd_val;
               if (is_mov_q) begin
                  state <= WRITE;
                  sel   <= dst_sel_q;
                  rf_we <= 1'b1;
                  rf_d  <= rd_val;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= rd_val;
               end
            end
            WRITE: begin
`ifdef RF_FLAG_UPDATE_EN
               if (!dst_f_q) begin
                  state <= FLAG;
                  sel   <= NREG'(1) << REG_F;
                  rf_we <= 1'b1;
                  rf_d  <= flag_d;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= data_q;
               end
`else
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_data  <= data_q;
`endif
            end
`ifdef RF_FLAG_UPDATE_EN
            FLAG: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_data  <= data_q;
            end
`endif
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_access_seq.sv
// Self-checking bench for rf_access_seq: directed vector table, multi-cycle
// corner sequences and a random op stream against a behavioural register-file model.
module tb_rf_access_seq;

`ifdef RF_FLAG_UPDATE_EN
   localparam int FL = 1;
`else
   localparam int FL = 0;
`endif
   localparam logic [1:0] NOP = 2'b00;
   localparam logic [1:0] LDI = 2'b01;
   localparam logic [1:0] RD  = 2'b10;
   localparam logic [1:0] MOV = 2'b11;
   localparam logic [7:0] FV  = (FL == 1) ? 8'h01 : 8'h02;

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [2:0] src;
      logic [2:0] dst;
      logic [7:0] imm;
      logic [7:0] ed;
      logic       ee;
      int         el;
   } tv_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [2:0] req_src = 3'd0;
   logic [2:0] req_dst = 3'd0;
   logic [7:0] req_imm = 8'h00;
   logic       rsp_valid, rsp_err;
   logic [7:0] rsp_data;
   logic       rf_as, rf_bs, rf_cs, rf_ds, rf_fs, rf_re, rf_we;
   logic [7:0] rf_d, rf_p, rf_fo;
   logic [4:0] sel;

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;
   int rsp_cnt = 0;
   int viol    = 0;

   logic [7:0] mem    [5] = '{default: 8'h00};
   logic [7:0] ref_rf [5] = '{default: 8'h00};
   logic [4:0] tr_sel [16];
   logic       tr_re  [16];
   logic       tr_we  [16];
   logic [7:0] tr_d   [16];

   always #5 clk = ~clk;

   rf_access_seq dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .req_imm   (req_imm),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rf_as     (rf_as),
      .rf_bs     (rf_bs),
      .rf_cs     (rf_cs),
      .rf_ds     (rf_ds),
      .rf_fs     (rf_fs),
      .rf_re     (rf_re),
      .rf_we     (rf_we),
      .rf_d      (rf_d),
      .rf_p      (rf_p),
      .rf_fo     (rf_fo)
   );

   assign sel   = {rf_fs, rf_ds, rf_cs, rf_bs, rf_as};
   assign rf_fo = mem[4];

   // Register file: p carries junk unless A..D is being read
   always_comb begin
      rf_p = 8'hC3;
      for (int i = 0; i < 4; i++) begin
         if (rf_re && sel[i]) rf_p = mem[i];
      end
   end

   always @(posedge clk) begin
      if (rf_we) begin
         for (int i = 0; i < 5; i++) begin
            if (sel[i]) mem[i] <= rf_d;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && req_valid && req_ready) acc_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (!$onehot0(sel) || (rf_re && rf_we)) viol++;
      if ((req_ready || rsp_valid) && ((sel != 5'b0) || rf_re || rf_we)) viol++;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: outcome of one request from the architectural rules
   task automatic model(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                        input logic [7:0] imm, output logic [7:0] ed, output logic ee,
                        output int el);
      logic       use_s, use_d, wr;
      logic [7:0] v;
      use_s = (op == RD) || (op == MOV);
      use_d = (op == LDI) || (op == MOV);
      ed = 8'h00; ee = 1'b0; el = 1; wr = 1'b0; v = 8'h00;
      if ((use_s && src > 3'd4) || (use_d && dst > 3'd4)) begin
         ee = 1'b1;
      end else begin
         case (op)
            LDI: begin v = imm; wr = 1'b1; end
            RD:  begin ed = ref_rf[int'(src)]; el = 2; end
            MOV: begin v = ref_rf[int'(src)]; wr = 1'b1; end
            default: ;
         endcase
         if (wr) begin
            ref_rf[int'(dst)] = v;
            ed = v;
            el = (op == MOV) ? 3 : 2;
            if (FL == 1 && dst != 3'd4) begin
               ref_rf[4] = {6'b0, v[7], (v == 8'h00)};
               el++;
            end
         end
      end
   endtask

   task automatic xfer(input string name, input logic [1:0] op, input logic [2:0] src,
                       input logic [2:0] dst, input logic [7:0] imm, input logic [7:0] ed,
                       input logic ee, input int el);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 20 && !req_ready; i++) begin
         @(posedge clk); #1;
      end
      req_valid = 1'b1; req_op = op; req_src = src; req_dst = dst; req_imm = imm;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c < 16; c++) begin
         @(negedge clk);
         tr_sel[c] = sel; tr_re[c] = rf_re; tr_we[c] = rf_we; tr_d[c] = rf_d;
         if (rsp_valid) begin
            lat = c;
            break;
         end
      end
      chk({name, "_lat"}, 64'(lat), 64'(el));
      chk({name, "_data"}, 64'(rsp_data), 64'(ed));
      chk({name, "_err"}, 64'(rsp_err), 64'(ee));
      @(negedge clk);
      chk({name, "_idle"}, 64'({rsp_valid, req_ready}), 64'(2'b01));
      chk({name, "_rf"}, 64'({mem[0], mem[1], mem[2], mem[3], mem[4]}),
          64'({ref_rf[0], ref_rf[1], ref_rf[2], ref_rf[3], ref_rf[4]}));
   endtask

   initial begin
      tv_t        tv[$];
      logic [7:0] ed;
      logic       ee;
      int         el;
      logic [1:0] op;
      logic [2:0] src, dst;
      logic [7:0] imm;
      int         found;

      tv.push_back('{"ldi_b",     LDI, 3'd7, 3'd1, 8'h5A, 8'h5A, 1'b0, 2 + FL});
      tv.push_back('{"ldi_a",     LDI, 3'd0, 3'd0, 8'h80, 8'h80, 1'b0, 2 + FL});
      tv.push_back('{"rd_b",      RD,  3'd1, 3'd7, 8'h00, 8'h5A, 1'b0, 2});
      tv.push_back('{"mov_a_d",   MOV, 3'd0, 3'd3, 8'h00, 8'h80, 1'b0, 3 + FL});
      tv.push_back('{"rd_d",      RD,  3'd3, 3'd0, 8'h00, 8'h80, 1'b0, 2});
      tv.push_back('{"ldi_f",     LDI, 3'd0, 3'd4, 8'h02, 8'h02, 1'b0, 2});
      tv.push_back('{"rd_f",      RD,  3'd4, 3'd0, 8'h00, 8'h02, 1'b0, 2});
      tv.push_back('{"ldi_c",     LDI, 3'd0, 3'd2, 8'h33, 8'h33, 1'b0, 2 + FL});
      tv.push_back('{"rd_c",      RD,  3'd2, 3'd0, 8'h00, 8'h33, 1'b0, 2});
      tv.push_back('{"ldi_bad6",  LDI, 3'd0, 3'd6, 8'h77, 8'h00, 1'b1, 1});
      tv.push_back('{"rd_bad5",   RD,  3'd5, 3'd0, 8'h00, 8'h00, 1'b1, 1});
      tv.push_back('{"mov_bad_d", MOV, 3'd2, 3'd7, 8'h00, 8'h00, 1'b1, 1});
      tv.push_back('{"mov_bad_s", MOV, 3'd7, 3'd2, 8'h00, 8'h00, 1'b1, 1});
      tv.push_back('{"nop",       NOP, 3'd7, 3'd7, 8'hFF, 8'h00, 1'b0, 1});
      tv.push_back('{"mov_c_c",   MOV, 3'd2, 3'd2, 8'h00, 8'h33, 1'b0, 3 + FL});
      tv.push_back('{"ldi_a0",    LDI, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 2 + FL});
      tv.push_back('{"rd_f2",     RD,  3'd4, 3'd0, 8'h00, FV,    1'b0, 2});
      tv.push_back('{"mov_f_b",   MOV, 3'd4, 3'd1, 8'h00, FV,    1'b0, 3 + FL});
      tv.push_back('{"mov_b_f",   MOV, 3'd1, 3'd4, 8'h00, FV,    1'b0, 3});
      tv.push_back('{"rd_f3",     RD,  3'd4, 3'd0, 8'h00, FV,    1'b0, 2});

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", 64'({sel, rf_re, rf_we, rf_d, rsp_valid, rsp_err, rsp_data}), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset for 3 cycles while a MOV sits in READ
      req_valid = 1'b1; req_op = MOV; req_src = 3'd0; req_dst = 3'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midmov_read", 64'({sel, rf_re, rf_we}), 64'({5'b00001, 1'b1, 1'b0}));
      repeat (2) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("midmov_rst", 64'({sel, rf_re, rf_we, rsp_valid}), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midmov_after", 64'({sel, rf_re, rf_we, rsp_valid}), 64'd0);
      chk("midmov_ready", 64'(req_ready), 64'd1);
      chk("midmov_rf", 64'({mem[0], mem[1], mem[2], mem[3], mem[4]}), 64'd0);

      // Directed table plus strobe-level checks on selected entries
      for (int i = 0; i < tv.size(); i++) begin
         model(tv[i].op, tv[i].src, tv[i].dst, tv[i].imm, ed, ee, el);
         xfer(tv[i].name, tv[i].op, tv[i].src, tv[i].dst, tv[i].imm, tv[i].ed, tv[i].ee, tv[i].el);
         if (i == 0)
            chk("ldi_b_wr", 64'({tr_sel[1], tr_re[1], tr_we[1], tr_d[1]}),
                64'({5'b00010, 1'b0, 1'b1, 8'h5A}));
         if (i == 2)
            chk("rd_b_dhold", 64'({tr_sel[1], tr_re[1], tr_we[1], tr_d[1]}),
                64'({5'b00010, 1'b1, 1'b0, (FL == 1) ? 8'h02 : 8'h80}));
         if (i == 3) begin
            chk("mov_rd", 64'({tr_sel[1], tr_re[1], tr_we[1]}), 64'({5'b00001, 1'b1, 1'b0}));
            chk("mov_wr", 64'({tr_sel[2], tr_re[2], tr_we[2], tr_d[2]}),
                64'({5'b01000, 1'b0, 1'b1, 8'h80}));
`ifdef RF_FLAG_UPDATE_EN
            chk("mov_flag", 64'({tr_sel[3], tr_re[3], tr_we[3], tr_d[3]}),
                64'({5'b10000, 1'b0, 1'b1, 8'h02}));
`endif
         end
         if (i == 6)
            chk("rd_f_sel", 64'({tr_sel[1], tr_re[1], tr_we[1]}), 64'({5'b10000, 1'b1, 1'b0}));
         if (i == 9)
            chk("bad_nostrobe", 64'({tr_sel[1], tr_re[1], tr_we[1]}), 64'd0);
         if (i == 14)
            chk("mov_cc", 64'({tr_sel[1], tr_re[1], tr_sel[2], tr_we[2], tr_d[2]}),
                64'({5'b00100, 1'b1, 5'b00100, 1'b1, 8'h33}));
      end

      // req_valid held across two LDIs: second accepted only after RESP
      model(LDI, 3'd0, 3'd0, 8'h11, ed, ee, el);
      model(LDI, 3'd0, 3'd0, 8'h11, ed, ee, el);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = LDI; req_src = 3'd0; req_dst = 3'd0; req_imm = 8'h11;
      @(posedge clk); #1;
      for (int c = 1; c <= el + 2; c++) begin
         @(negedge clk);
         if (c < el)  chk("b2b_busy", 64'({req_ready, rsp_valid}), 64'(2'b00));
         if (c == el) chk("b2b_rsp1", 64'({req_ready, rsp_valid}), 64'(2'b01));
         if (c == el + 1) chk("b2b_idle", 64'({req_ready, rsp_valid}), 64'(2'b10));
         if (c == el + 2) chk("b2b_acc2", 64'({req_ready, rf_we}), 64'(2'b01));
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(negedge clk);
         if (rsp_valid) found = 1;
      end
      chk("b2b_rsp2", 64'(found), 64'd1);
      @(negedge clk);
      chk("b2b_rf", 64'({mem[0], mem[1], mem[2], mem[3], mem[4]}),
          64'({ref_rf[0], ref_rf[1], ref_rf[2], ref_rf[3], ref_rf[4]}));

      // Random op stream
      for (int n = 0; n < 200; n++) begin
         op  = 2'($urandom_range(0, 3));
         src = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         dst = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         imm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         model(op, src, dst, imm, ed, ee, el);
         xfer("rnd", op, src, dst, imm, ed, ee, el);
      end

      chk("invariants", 64'(viol), 64'd0);
      // The MOV abandoned by reset is the only accept without a response
      chk("acc_vs_rsp", 64'(acc_cnt - rsp_cnt), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
